// File: rtl/demux_frame_router.sv
// demux_frame_router: deframes a serial stream (start bit, 3-bit channel
// address MSB first, DATA_BITS payload bits) and drives the select and data
// inputs of a 1-to-8 DeMUX so each payload bit reaches only its channel.
module demux_frame_router #(
    parameter int DATA_BITS = 8,   // payload bits per frame, 1..255
    parameter int CNT_W     = 8    // payload counter width, must hold DATA_BITS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       din_valid,
    input  logic       abort,
    output logic [2:0] sel,
    output logic       dout,
    output logic       dout_valid,
    output logic       frame_done,
    output logic       busy,
    output logic [7:0] frame_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    // Counter value at which the sampled payload bit is the last one.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    logic [1:0]       state;
    logic [2:0]       addr_sr;
    logic [1:0]       addr_cnt;
    logic [CNT_W-1:0] bit_cnt;

    // Framing FSM, address capture, payload steering and frame counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            sel         <= 3'd0;
            dout        <= 1'b0;
            dout_valid  <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 8'd0;
            addr_sr     <= 3'd0;
            addr_cnt    <= 2'd0;
            bit_cnt     <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // reads the pre-edge register values regardless of statement order.
            // Output strobes default low each cycle; dout is forced to 0 with
            // them so idle DeMUX channels never see a 1.
            dout_valid <= 1'b0;
            dout       <= 1'b0;
            frame_done <= 1'b0;

            if (abort && (state != IDLE)) begin
                // Abort wins over a simultaneous valid bit; sel and
                // frame_count keep their values.
                state    <= IDLE;
                busy     <= 1'b0;
                addr_sr  <= 3'd0;
                addr_cnt <= 2'd0;
                bit_cnt  <= '0;
            end else if (din_valid) begin
                case (state)
                    IDLE: begin
                        if (din) begin
                            state    <= ADDR;
                            busy     <= 1'b1;
                            addr_cnt <= 2'd0;
                        end
                    end
                    ADDR: begin
                        addr_sr  <= {addr_sr[1:0], din};
                        addr_cnt <= addr_cnt + 2'd1;
                        if (addr_cnt == 2'd2) begin
                            // Third address bit: sel updates once per frame
                            // and stays put for the whole payload.
                            sel      <= {addr_sr[1:0], din};
                            state    <= DATA;
                            addr_cnt <= 2'd0;
                            bit_cnt  <= '0;
                        end
                    end
                    DATA: begin
                        dout       <= din;
                        dout_valid <= 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 8'd1;
                            state       <= IDLE;
                            busy        <= 1'b0;
                            bit_cnt     <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_demux_frame_router.sv
// tb_demux_frame_router: scoreboard bench. The driver pushes the expected
// (sel, bit, last) for every payload bit it sends; a monitor on the falling
// edge pops one entry per dout_valid and checks idle outputs otherwise.
module tb_demux_frame_router;

    localparam int DB = 8;

    typedef struct {
        logic [2:0] sel;
        logic       bit_v;
        logic       last;
    } sb_item_t;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic       din_valid;
    logic       abort;
    logic [2:0] sel;
    logic       dout;
    logic       dout_valid;
    logic       frame_done;
    logic       busy;
    logic [7:0] frame_count;

    sb_item_t   sb[$];
    logic [7:0] exp_fc;
    int         total;
    int         bad;

    demux_frame_router #(.DATA_BITS(DB), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .abort       (abort),
        .sel         (sel),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .frame_done  (frame_done),
        .busy        (busy),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one valid bit; optionally push its expected output, optionally
    // follow it with one stall cycle.
    task automatic put(input logic b, input bit stall, input bit is_pl,
                       input bit last, input logic [2:0] s);
        sb_item_t it;
        @(negedge clk);
        din       = b;
        din_valid = 1'b1;
        abort     = 1'b0;
        if (is_pl) begin
            it.sel   = s;
            it.bit_v = b;
            it.last  = last;
            sb.push_back(it);
        end
        if (stall) begin
            @(negedge clk);
            din       = 1'($urandom);
            din_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din       = 1'($urandom);
            din_valid = 1'b0;
            abort     = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [2:0] a, input logic [DB-1:0] d, input bit stall);
        put(1'b1, stall, 0, 0, 3'd0);
        for (int k = 2; k >= 0; k--) put(a[k], stall, 0, 0, 3'd0);
        @(posedge clk);
        #1;
        check("sel_after_addr", sel, a);
        check("busy_in_frame", busy, 1);
        for (int k = DB - 1; k >= 0; k--) put(d[k], stall, 1, (k == 0), a);
    endtask

    // Monitor: compare outputs on the falling edge, clear the model in reset.
    always @(negedge clk) begin
        sb_item_t it;
        if (!rst_n) begin
            sb.delete();
            exp_fc = 8'd0;
        end else begin
            if (dout_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_dout_valid", 1, 0);
                end else begin
                    it = sb.pop_front();
                    check("dout", dout, it.bit_v);
                    check("sel_payload", sel, it.sel);
                    check("frame_done", frame_done, it.last);
                    if (it.last) exp_fc = exp_fc + 8'd1;
                end
            end else begin
                check("dout_idle", dout, 0);
                check("frame_done_idle", frame_done, 0);
            end
            check("frame_count", frame_count, exp_fc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fc_before;
        total     = 0;
        bad       = 0;
        exp_fc    = 8'd0;
        rst_n     = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        abort     = 1'b0;

        // Reset held with random line activity: outputs stay zero.
        repeat (6) begin
            @(negedge clk);
            din       = 1'($urandom);
            din_valid = 1'($urandom);
            #1;
            check("rst_sel", sel, 0);
            check("rst_dout", dout, 0);
            check("rst_dout_valid", dout_valid, 0);
            check("rst_frame_done", frame_done, 0);
            check("rst_busy", busy, 0);
            check("rst_frame_count", frame_count, 0);
        end
        din_valid = 1'b0;
        #1 rst_n = 1'b1;
        idle(2);
        check("busy_after_rst", busy, 0);

        // 256 back-to-back frames, addresses 0..7 repeating; count wraps.
        for (int i = 0; i < 256; i++) send_frame(3'(i), 8'($urandom), 0);
        idle(2);
        check("fc_wrap", frame_count, 0);
        check("busy_after_b2b", busy, 0);

        // Basic frame: address 5, payload 10110011.
        send_frame(3'd5, 8'b1011_0011, 0);
        idle(2);
        check("fc_basic", frame_count, 1);
        check("busy_after_basic", busy, 0);

        // Same frame with a stall after every valid bit.
        send_frame(3'd5, 8'b1011_0011, 1);
        idle(2);
        check("sel_after_stall", sel, 5);
        check("fc_stall", frame_count, 2);

        // Abort after address 3 and four payload bits.
        fc_before = frame_count;
        put(1'b1, 0, 0, 0, 3'd0);
        put(1'b0, 0, 0, 0, 3'd0);
        put(1'b1, 0, 0, 0, 3'd0);
        put(1'b1, 0, 0, 0, 3'd0);
        for (int k = 0; k < 4; k++) put(1'($urandom), 0, 1, 0, 3'd3);
        @(negedge clk);
        din       = 1'b1;
        din_valid = 1'b1;
        abort     = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        din_valid = 1'b0;
        check("abort_dout_valid", dout_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_sel_hold", sel, 3);
        check("abort_fc_hold", frame_count, fc_before);
        idle(1);
        send_frame(3'd6, 8'($urandom), 0);
        idle(2);
        check("fc_after_abort", frame_count, 8'(fc_before + 8'd1));

        // Async reset during payload bit 4.
        put(1'b1, 0, 0, 0, 3'd0);
        put(1'b1, 0, 0, 0, 3'd0);
        put(1'b0, 0, 0, 0, 3'd0);
        put(1'b1, 0, 0, 0, 3'd0);
        for (int k = 0; k < 3; k++) put(1'($urandom), 0, 1, 0, 3'd5);
        @(negedge clk);
        din       = 1'b1;
        din_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("arst_dout_valid", dout_valid, 0);
        check("arst_dout", dout, 0);
        check("arst_frame_done", frame_done, 0);
        check("arst_busy", busy, 0);
        check("arst_sel", sel, 0);
        check("arst_frame_count", frame_count, 0);
        repeat (2) @(negedge clk);
        din_valid = 1'b0;
        #1 rst_n = 1'b1;
        idle(1);
        send_frame(3'd5, 8'b1011_0011, 0);
        idle(3);
        check("fc_after_arst", frame_count, 1);
        check("busy_after_arst", busy, 0);
        check("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_frame_router.md
Name: demux_frame_router

Overview:
- Upstream stage for the 1-to-8 DeMUX.
- Receives a serial bit stream framed as a start bit, then a 3-bit channel address, then DATA_BITS payload bits.
- Drives the DeMUX select (sel) and data input (dout), so each payload bit is steered to the addressed channel only.
- Provides framing status, an abort path and a frame counter.

Parameters:
- DATA_BITS, 8, payload bits per frame; legal range 1..255.
- CNT_W, 8, width of the payload bit counter; must hold DATA_BITS.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  1  serial data bit.
- din_valid  input  1  din is sampled only when high; low means stall.
- abort  input  1  synchronous frame abort.
- sel  output  3  channel select to the DeMUX; registered.
- dout  output  1  payload bit to the DeMUX data input; registered.
- dout_valid  output  1  dout carries a payload bit this cycle.
- frame_done  output  1  one-cycle pulse with the last payload bit.
- busy  output  1  high in ADDR or DATA.
- frame_count  output  8  completed-frame counter; wraps 255->0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sel=0, dout=0, dout_valid=0, frame_done=0, busy=0, frame_count=0, address shift register and bit counter=0.
- Reset asserted mid-frame discards the frame immediately; no frame_done and no count increment.
- Reset applies at any time, independent of clk.

FSM states:
- IDLE:
  - din_valid=1 and din=1 (start bit) -> ADDR, addr_cnt=0.
  - din=0 with din_valid=1 is idle line; ignored.
- ADDR:
  - Each valid bit shifts into the address register, MSB first.
  - On the 3rd valid bit: sel <= {a2,a1,a0} on that clock edge -> DATA, bit_cnt=0.
- DATA:
  - Each valid bit: dout <= din and dout_valid <= 1 on the next edge, giving 1-cycle latency from sampled bit to output.
  - bit_cnt increments per valid bit.
  - On bit DATA_BITS: frame_done=1 in the same cycle as that last dout_valid; frame_count += 1 (mod 256); -> IDLE.

Stall, output and abort rules:
- din_valid=0 in any state: no state change, counters hold, dout_valid=0, dout=0.
- dout is forced to 0 whenever dout_valid=0, so idle channels never see a 1.
- sel changes only at the end of the address phase and holds its value between frames and through IDLE.
- sel is therefore stable for the entire payload of a frame.
- busy=1 in ADDR and DATA, 0 in IDLE; registered together with the state.
- abort=1: synchronous return to IDLE next edge; clear dout_valid, dout and frame_done; counters reset; sel and frame_count hold.
- abort beats a simultaneous din_valid; that bit is discarded.
- abort in IDLE has no effect.

Back-to-back frames:
- The cycle in which the final payload bit is sampled moves the FSM to IDLE.
- A start bit on the very next valid cycle is accepted, so there are zero dead cycles between frames.

Widths:
- bit_cnt is CNT_W bits; the compare is against DATA_BITS exactly (bit_cnt == DATA_BITS-1 at the sampled bit).
- No overflow is possible within legal DATA_BITS.

Test Plan:
- Reset: hold rst_n=0, drive random din/din_valid -> all outputs 0, frame_count=0. Release -> still IDLE, busy=0.
- Basic frame, DATA_BITS=8:
  - Stream 1, 1,0,1, 10110011 with din_valid=1 every cycle.
  - sel=5 from the cycle after the 3rd address bit.
  - dout_valid high for 8 consecutive cycles with dout=1,0,1,1,0,0,1,1.
  - frame_done high only with the 8th bit; frame_count=1; busy drops.
- Stalls: same frame with din_valid toggling 1,0,1,0 -> identical dout sequence with gaps; dout=0 in gap cycles; sel stays 5.
- Abort:
  - Send address 3, then 4 data bits, then abort=1 together with din_valid=1.
  - Next cycle IDLE, dout_valid=0, no frame_done, frame_count unchanged, sel stays 3.
  - Next frame with address 6 routes correctly.
- Back-to-back and wrap:
  - 256 consecutive frames with no idle gaps, addresses cycling 0..7.
  - Each frame_done pulse aligns with its last bit; frame_count wraps to 0 after frame 256.
  - sel sequence is 0..7 repeating.
- Async reset mid-payload: drop rst_n during bit 4 of a frame -> outputs clear immediately (before the next clk edge), frame_count=0; a subsequent full frame behaves as in the basic frame scenario.
